dram_cmd_arbiter: RTL

- Shares the single DRAM command/address bus among NUM_BANKS per-bank FSMs.
- Each bank FSM raises a request while sitting in a *_CHECK state. The arbiter grants at most one eligible bank per cycle, round-robin, and only if every JEDEC-style spacing constraint is met.
- Non-granted banks are held via their stall input.
- The granted command is registered onto the DRAM command bus one cycle later.

---
 rtl/dram_cmd_arbiter_if.sv | 29 ++
 rtl/dram_cmd_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_arbiter_if.sv
// Command-bus interface between the per-bank FSMs and the DRAM command arbiter.
// The bank side (master) drives requests; the arbiter (slave) returns
// grant/stall and drives the registered DRAM command bus.
interface dram_cmd_arbiter_if #(
  parameter int NUM_BANKS = 8,
  parameter int ADDR_BITS = 14
);
  localparam int BA_W = $clog2(NUM_BANKS);

  logic [NUM_BANKS-1:0]           req;
  logic [3*NUM_BANKS-1:0]         req_cmd;
  logic [ADDR_BITS*NUM_BANKS-1:0] req_addr;
  logic [NUM_BANKS-1:0]           stall;
  logic [NUM_BANKS-1:0]           grant;
  logic                           cmd_valid;
  logic [2:0]                     cmd_out;
  logic [BA_W-1:0]                cmd_ba;
  logic [ADDR_BITS-1:0]           cmd_addr;

  modport master (
    output req, req_cmd, req_addr,
    input  stall, grant, cmd_valid, cmd_out, cmd_ba, cmd_addr
  );

  modport slave (
    input  req, req_cmd, req_addr,
    output stall, grant, cmd_valid, cmd_out, cmd_ba, cmd_addr
  );
endinterface

// File: rtl/dram_cmd_arbiter.sv
// DRAM command arbiter: shares the single command/address bus among the
// per-bank FSMs. One eligible bank is granted per cycle, round-robin from the
// pointer, and only when every spacing counter allows the command. The
// granted command appears on the bus one cycle after the grant.
module dram_cmd_arbiter #(
  parameter int NUM_BANKS = 8,
  parameter int ADDR_BITS = 14,
  parameter int T_RCD     = 4,
  parameter int T_RP      = 4,
  parameter int T_RRD     = 2,
  parameter int T_CCD     = 2,
  parameter int T_WTR     = 3,
  parameter int T_RTW     = 4
) (
  input logic               clk,
  input logic               rst_n,
  dram_cmd_arbiter_if.slave bus
);
  localparam int BA_W = $clog2(NUM_BANKS);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  // Counters hold "cycles still to wait"; a grant loads T-1 so the next
  // constrained grant lands exactly T cycles later.
  localparam logic [4:0] RCD_LD = 5'(T_RCD - 1);
  localparam logic [4:0] RP_LD  = 5'(T_RP - 1);
  localparam logic [4:0] RRD_LD = 5'(T_RRD - 1);
  localparam logic [4:0] CCD_LD = 5'(T_CCD - 1);
  localparam logic [4:0] WTR_LD = 5'(T_WTR - 1);
  localparam logic [4:0] RTW_LD = 5'(T_RTW - 1);

  localparam logic [NUM_BANKS-1:0] ONE_HOT_0 = {{(NUM_BANKS-1){1'b0}}, 1'b1};
  localparam logic [BA_W-1:0]      BA_ONE    = BA_W'(1'b1);

  logic [2:0]           cmd_a_s  [NUM_BANKS];
  logic [ADDR_BITS-1:0] addr_a_s [NUM_BANKS];
  logic [4:0]           rcd_cnt_r [NUM_BANKS];
  logic [4:0]           rp_cnt_r  [NUM_BANKS];
  logic [4:0]           rrd_cnt_r;
  logic [4:0]           ccd_cnt_r;
  logic [4:0]           wtr_cnt_r;
  logic [4:0]           rtw_cnt_r;
  logic [BA_W-1:0]      rr_ptr_r;
  logic                 all_rp_zero_s;
  logic [NUM_BANKS-1:0] elig_s;
  logic                 found_s;
  logic [BA_W-1:0]      win_s;
  logic [2:0]           win_cmd_s;
  logic [NUM_BANKS-1:0] grant_s;
  logic                 cmd_valid_r;
  logic [2:0]           cmd_out_r;
  logic [BA_W-1:0]      cmd_ba_r;
  logic [ADDR_BITS-1:0] cmd_addr_r;

  // Saturating decrement: a counter at zero stays there.
  function automatic logic [4:0] cnt_dec(input logic [4:0] c);
    if (c == 5'd0) begin
      return 5'd0;
    end else begin
      return c - 5'd1;
    end
  endfunction

  // Split the flat request buses into per-bank command and address.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      cmd_a_s[i]  = bus.req_cmd[3*i +: 3];
      addr_a_s[i] = bus.req_addr[ADDR_BITS*i +: ADDR_BITS];
    end
  end

  // REF needs every bank's precharge window closed.
  always_comb begin
    all_rp_zero_s = 1'b1;
    for (int i = 0; i < NUM_BANKS; i++) begin
      all_rp_zero_s = all_rp_zero_s & (rp_cnt_r[i] == 5'd0);
    end
  end

  // Per-bank eligibility from the requested command and the spacing counters.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      case (cmd_a_s[i])
        CMD_ACT: elig_s[i] = bus.req[i] && (rp_cnt_r[i] == 5'd0) && (rrd_cnt_r == 5'd0);
        CMD_RD:  elig_s[i] = bus.req[i] && (rcd_cnt_r[i] == 5'd0) && (ccd_cnt_r == 5'd0)
                             && (wtr_cnt_r == 5'd0);
        CMD_WR:  elig_s[i] = bus.req[i] && (rcd_cnt_r[i] == 5'd0) && (ccd_cnt_r == 5'd0)
                             && (rtw_cnt_r == 5'd0);
        CMD_PRE: elig_s[i] = bus.req[i];
        CMD_REF: elig_s[i] = bus.req[i] && all_rp_zero_s;
        CMD_NOP: elig_s[i] = 1'b0;
        default: elig_s[i] = 1'b0;
      endcase
    end
  end

  // Round-robin pick: first eligible bank at or after the pointer, wrapping.
  always_comb begin
    logic [BA_W-1:0] idx_v;
    logic            take_v;
    idx_v   = '0;
    take_v  = 1'b0;
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      idx_v   = rr_ptr_r + BA_W'(k);
      take_v  = !found_s && elig_s[idx_v];
      win_s   = take_v ? idx_v : win_s;
      found_s = found_s | take_v;
    end
  end

  // Grant is suppressed while reset is asserted, which also forces stall high.
  always_comb begin
    win_cmd_s = cmd_a_s[win_s];
    if (rst_n && found_s) begin
      grant_s = ONE_HOT_0 << win_s;
    end else begin
      grant_s = '0;
    end
  end

  assign bus.grant     = grant_s;
  assign bus.stall     = ~grant_s;
  assign bus.cmd_valid = cmd_valid_r;
  assign bus.cmd_out   = cmd_out_r;
  assign bus.cmd_ba    = cmd_ba_r;
  assign bus.cmd_addr  = cmd_addr_r;

  // Spacing counters: load on the matching grant, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        rcd_cnt_r[i] <= 5'd0;
        rp_cnt_r[i]  <= 5'd0;
      end
      rrd_cnt_r <= 5'd0;
      ccd_cnt_r <= 5'd0;
      wtr_cnt_r <= 5'd0;
      rtw_cnt_r <= 5'd0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (found_s && (win_s == BA_W'(i)) && (win_cmd_s == CMD_ACT)) begin
          rcd_cnt_r[i] <= RCD_LD;
        end else begin
          rcd_cnt_r[i] <= cnt_dec(rcd_cnt_r[i]);
        end
        if (found_s && (((win_s == BA_W'(i)) && (win_cmd_s == CMD_PRE))
                        || (win_cmd_s == CMD_REF))) begin
          rp_cnt_r[i] <= RP_LD;
        end else begin
          rp_cnt_r[i] <= cnt_dec(rp_cnt_r[i]);
        end
      end
      rrd_cnt_r <= (found_s && (win_cmd_s == CMD_ACT)) ? RRD_LD : cnt_dec(rrd_cnt_r);
      ccd_cnt_r <= (found_s && ((win_cmd_s == CMD_RD) || (win_cmd_s == CMD_WR)))
                   ? CCD_LD : cnt_dec(ccd_cnt_r);
      wtr_cnt_r <= (found_s && (win_cmd_s == CMD_WR)) ? WTR_LD : cnt_dec(wtr_cnt_r);
      rtw_cnt_r <= (found_s && (win_cmd_s == CMD_RD)) ? RTW_LD : cnt_dec(rtw_cnt_r);
    end
  end

  // Pointer advance and registered command bus; bank/address hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r    <= '0;
      cmd_valid_r <= 1'b0;
      cmd_out_r   <= CMD_NOP;
      cmd_ba_r    <= '0;
      cmd_addr_r  <= '0;
    end else if (found_s) begin
      rr_ptr_r    <= win_s + BA_ONE;
      cmd_valid_r <= 1'b1;
      cmd_out_r   <= win_cmd_s;
      cmd_ba_r    <= win_s;
      cmd_addr_r  <= addr_a_s[win_s];
    end else begin
      cmd_valid_r <= 1'b0;
      cmd_out_r   <= CMD_NOP;
    end
  end
endmodule
